// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Five-state multicycle core for a small MIPS-like subset. Instructions and
//   data share one memory port. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and then returns to FETCH.
//
//   Memory handshake: mem_req means a transaction is being offered. The
//   address, write enable and write data stay stable until mem_ready is high.
//   The transaction completes on the rising edge at which mem_req and
//   mem_ready are both high. mem_rdata is used only on that edge.
//
// Ports
//   CLK                 single clock, rising-edge
//   rst                 synchronous, active-high reset
//   mem_req / mem_we    transaction request / write enable (valid with req)
//   mem_addr            byte address (pc in FETCH, alu_out in MEM)
//   mem_wdata           store data (operand B)
//   mem_ready           transaction completes this cycle
//   mem_rdata           read data; instruction is bits [31:0]
//   pc                  current program counter
//   alu_out             registered ALU result
//   result              last register write-back value
//   retire              one-cycle pulse per completed instruction
//   illegal             one-cycle pulse on an unsupported opcode/funct
//   The internal 'state' signal holds the FSM state for debug and binding.

module multicycle_datapath #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                NREGS    = 32
) (
    input  logic              CLK,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] result,
    output logic              retire,
    output logic              illegal
);

    localparam int RW = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t            state, state_next;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q, b_q, imm_q, mdr;
    logic [DATA_W-1:0] regs [NREGS];

    // ------------------------------------------------------------------
    // Instruction fields and decode
    // ------------------------------------------------------------------
    logic [5:0]    op, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
    logic          is_rtype, is_alu_r, is_jr, is_addi, is_lw, is_sw;
    logic          is_beq, is_j, is_jal, is_legal, uses_alu;
    logic          unused_ir;

    assign op     = ir[31:26];
    assign funct  = ir[5:0];
    assign rs_idx = ir[21 +: RW];
    assign rt_idx = ir[16 +: RW];
    assign rd_idx = ir[11 +: RW];

    // The shift-amount field has no meaning in this subset. With fewer than
    // 32 registers the upper index bits are ignored as well.
    assign unused_ir = ^{ir[10:6], ir[25:11]};

    assign is_rtype = (op == OP_RTYPE);
    assign is_alu_r = is_rtype && (funct == F_ADD || funct == F_SUB ||
                                   funct == F_AND || funct == F_OR  ||
                                   funct == F_SLT);
    assign is_jr    = is_rtype && (funct == F_JR);
    assign is_addi  = (op == OP_ADDI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign uses_alu = is_alu_r || is_addi || is_lw || is_sw;
    assign is_legal = uses_alu || is_jr || is_beq || is_j || is_jal;

    // Register 0 always reads as zero, regardless of what the array holds.
    logic [DATA_W-1:0] rs_val, rt_val;
    assign rs_val = (rs_idx == '0) ? '0 : regs[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : regs[rt_idx];

    // The jump target keeps the top bits of the already incremented pc.
    logic [DATA_W-1:0] jump_target;
    assign jump_target = {pc[DATA_W-1:28], ir[25:0], 2'b00};

    // ------------------------------------------------------------------
    // ALU: R-type uses B, every other ALU user adds the sign-extended immediate
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_res;
    always_comb begin
        alu_res = a_q + imm_q;
        if (is_rtype) begin
            case (funct)
                F_SUB:   alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = ($signed(a_q) < $signed(b_q)) ?
                                   {{(DATA_W-1){1'b0}}, 1'b1} : '0;
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    // Write-back source and destination
    logic [DATA_W-1:0] wb_val;
    assign wb_val = is_lw ? mdr : alu_out;
    assign wb_idx = is_rtype ? rd_idx : rt_idx;

    // ------------------------------------------------------------------
    // Next state and memory port outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        mem_wdata  = b_q;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (is_alu_r || is_addi) state_next = WB;
                else if (is_lw || is_sw) state_next = MEM;
                else                     state_next = FETCH;
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_out;
                mem_we   = is_sw;
                if (mem_ready) state_next = is_sw ? FETCH : WB;
            end
            WB:      state_next = FETCH;
            default: state_next = FETCH;
        endcase
        // While reset is asserted, nothing is offered to memory. A
        // transaction in progress is dropped without any side effect.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            mdr     <= '0;
            alu_out <= '0;
            result  <= '0;
            retire  <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state   <= state_next;
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + DATA_W'(4);
                    end
                end
                DECODE: begin
                    a_q   <= rs_val;
                    b_q   <= rt_val;
                    imm_q <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
                end
                EXEC: begin
                    if (uses_alu) alu_out <= alu_res;
                    if (is_beq) begin
                        // pc already points past the branch
                        if (a_q == b_q) pc <= pc + (imm_q << 2);
                        retire <= 1'b1;
                    end
                    if (is_j) begin
                        pc     <= jump_target;
                        retire <= 1'b1;
                    end
                    if (is_jal) begin
                        pc                <= jump_target;
                        regs[NREGS-1]     <= pc;
                        result            <= pc;
                        retire            <= 1'b1;
                    end
                    if (is_jr) begin
                        pc     <= a_q;
                        retire <= 1'b1;
                    end
                    if (!is_legal) begin
                        illegal <= 1'b1;
                        retire  <= 1'b1;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_sw) retire <= 1'b1;
                        else       mdr    <= mem_rdata;
                    end
                end
                WB: begin
                    if (wb_idx != '0) regs[wb_idx] <= wb_val;
                    result <= wb_val;
                    retire <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath
//   Directed programs and a random program run on a 32-bit instance. An
//   instruction-level reference model predicts pc, result, illegal, latency
//   and stores for every instruction. A 64-bit instance runs in lockstep
//   during the directed programs to check wrap and signed compare at the
//   wider width.

module tb_multicycle_datapath;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- 32-bit DUT ----------------
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, alu_out, result;

  multicycle_datapath dut (
    .CLK(CLK), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .alu_out(alu_out), .result(result),
    .retire(retire), .illegal(illegal)
  );

  // ---------------- 64-bit DUT (shares the memory responses) ----------------
  logic        mem_req64, mem_we64, retire64, illegal64;
  logic [63:0] mem_addr64, mem_wdata64, mem_rdata64, pc64, alu_out64, result64;
  logic        unused_64;
  assign mem_rdata64 = {32'h0, mem_rdata};
  assign unused_64   = ^{mem_req64, mem_we64, mem_addr64, mem_wdata64, alu_out64};

  multicycle_datapath #(.DATA_W(64)) dut64 (
    .CLK(CLK), .rst(rst),
    .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64),
    .mem_wdata(mem_wdata64), .mem_ready(mem_ready), .mem_rdata(mem_rdata64),
    .pc(pc64), .alu_out(alu_out64), .result(result64),
    .retire(retire64), .illegal(illegal64)
  );

  // ---------------- memory responder ----------------
  logic [31:0] mem [1024];
  int          cur_wait = 0;
  int          wait_cnt = 0;

  assign mem_ready = mem_req && (wait_cnt >= cur_wait);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge CLK) begin
    if (rst || !mem_req || mem_ready) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // expected stores {addr, data}
  logic [63:0] wr_q[$];    // observed stores
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [1024];
  logic [31:0] m_pc, m_result;
  logic [31:0] exp_pc, exp_res;
  logic        exp_ill;
  int          exp_cyc;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0;
    m_result = '0;
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] v);
    if (idx != 0) m_regs[idx] = v;
    m_result = v;
  endtask

  task automatic model_step(input int w);
    logic [31:0] ir, a, b, simm, npc, addr;
    logic [5:0]  op, fn;
    int rs, rt, rd, base, nacc;
    ir   = m_mem[m_pc[11:2]];
    op   = ir[31:26];
    fn   = ir[5:0];
    rs   = int'(ir[25:21]);
    rt   = int'(ir[20:16]);
    rd   = int'(ir[15:11]);
    a    = m_regs[rs];
    b    = m_regs[rt];
    simm = {{16{ir[15]}}, ir[15:0]};
    npc  = m_pc + 32'd4;
    addr = a + simm;
    exp_ill = 1'b0;
    base = 3;
    nacc = 1;
    case (op)
      6'h00: begin
        base = 4;
        case (fn)
          6'h20: wr_reg(rd, a + b);
          6'h22: wr_reg(rd, a - b);
          6'h24: wr_reg(rd, a & b);
          6'h25: wr_reg(rd, a | b);
          6'h2A: wr_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h08: begin npc = a; base = 3; end
          default: begin exp_ill = 1'b1; base = 3; end
        endcase
      end
      6'h08: begin base = 4; wr_reg(rt, a + simm); end
      6'h23: begin base = 5; nacc = 2; wr_reg(rt, m_mem[addr[11:2]]); end
      6'h2B: begin
        base = 4; nacc = 2;
        m_mem[addr[11:2]] = b;
        exp_q.push_back({addr, b});
      end
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h02: npc = {npc[31:28], ir[25:0], 2'b00};
      6'h03: begin
        npc = {npc[31:28], ir[25:0], 2'b00};
        wr_reg(31, m_pc + 32'd4);
      end
      default: exp_ill = 1'b1;
    endcase
    m_pc    = npc;
    exp_pc  = npc;
    exp_res = m_result;
    exp_cyc = base + w * nacc;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction
  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_op(input int op, input int target);
    return {6'(op), 26'(target)};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    mem[addr/4]   = w;
    m_mem[addr/4] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [5];
    int k;
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 8: return r_op($urandom_range(0, 31), $urandom_range(0, 31),
                           $urandom_range(1, 31), int'(fl[$urandom_range(0, 4)]));
      2, 7:    return i_op(8, $urandom_range(0, 31), $urandom_range(0, 31),
                           $urandom_range(0, 65535));
      3:       return i_op(8'h23, 0, $urandom_range(0, 31), 'h800 + 4 * $urandom_range(0, 63));
      4:       return i_op(8'h2B, 0, $urandom_range(0, 31), 'h800 + 4 * $urandom_range(0, 63));
      5: begin
        int r1;
        r1 = $urandom_range(0, 31);
        return i_op(4, r1, ($urandom_range(0, 1) == 1) ? r1 : $urandom_range(0, 31),
                    $urandom_range(0, 3));
      end
      default: begin
        case ($urandom_range(0, 3))
          0:       return {6'h3F, 26'(the_rand26())};
          1:       return {6'h01, 26'(the_rand26())};
          2:       return r_op(1, 2, 3, 6'h3F);
          default: return r_op(4, 5, 6, 6'h00);
        endcase
      end
    endcase
  endfunction

  function automatic int the_rand26();
    return int'($urandom_range(0, 32'h03FF_FFFF));
  endfunction

  // ---------------- driver tasks ----------------
  bit check64 = 1'b0;

  task automatic capture_write();
    if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[11:2]] = mem_wdata;
      wr_q.push_back({mem_addr, mem_wdata});
    end
  endtask

  task automatic wait_retire(output int cyc);
    cyc = 0;
    do begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      capture_write();
    end while (!retire && cyc < 60);
  endtask

  // Run one instruction with the given memory wait and compare everything.
  task automatic step(input int w, input string name, output int cyc);
    logic [63:0] e, o;
    cur_wait = w;
    model_step(w);
    wait_retire(cyc);
    check({name, "_retire"},  64'(retire),  64'(1));
    check({name, "_latency"}, 64'(cyc),     64'(exp_cyc));
    check({name, "_pc"},      64'(pc),      64'(exp_pc));
    check({name, "_result"},  64'(result),  64'(exp_res));
    check({name, "_illegal"}, 64'(illegal), 64'(exp_ill));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
      check({name, "_store"}, o, e);
    end else begin
      check({name, "_no_store"}, 64'(wr_q.size()), 64'(0));
    end
    if (check64) begin
      check({name, "_pc64"},     pc64,            {32'h0, exp_pc});
      check({name, "_retire64"}, 64'(retire64),   64'(1));
      check({name, "_illegal64"}, 64'(illegal64), 64'(exp_ill));
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    rst = 1'b1;
    cur_wait = 0;
    repeat (2) @(negedge CLK);
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we",  64'(mem_we),  64'(0));
    check("rst_pc",      64'(pc),      64'(0));
    check("rst_result",  64'(result),  64'(0));
    check("rst_alu_out", 64'(alu_out), 64'(0));
    check("rst_retire",  64'({retire, illegal}), 64'(0));
    model_reset();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c, tot;

    // Program A: arithmetic, then store/load through a two-cycle memory
    apply_reset();
    clear_mem();
    put('h00, i_op(8, 0, 1, 5));
    put('h04, i_op(8, 0, 2, 7));
    put('h08, r_op(1, 2, 3, 'h20));
    put('h0C, i_op('h2B, 0, 3, 4));
    put('h10, i_op('h23, 0, 4, 4));
    check64 = 1'b1;
    rst = 1'b0;
    tot = 0;
    step(0, "addi_r1", c); tot += c;
    step(0, "addi_r2", c); tot += c;
    step(0, "add_r3", c);  tot += c;
    check("add_total_cycles", 64'(tot),    64'(12));
    check("add_value",        64'(result), 64'(12));
    check("add_pc",           64'(pc),     64'(12));
    step(1, "sw_r3", c);
    check("sw_latency_wait", 64'(c), 64'(6));
    step(1, "lw_r4", c);
    check("lw_latency_wait", 64'(c),      64'(7));
    check("lw_value",        64'(result), 64'(12));

    // Program B: control flow, illegal, wrap and signed compare
    apply_reset();
    clear_mem();
    put('h00, i_op(8, 0, 1, 3));
    put('h04, j_op(2, 'h10 >> 2));
    put('h10, i_op(4, 1, 1, 2));
    put('h1C, i_op(4, 1, 0, 5));
    put('h20, j_op(3, 'h40));
    put('h100, r_op(31, 0, 0, 'h08));
    put('h24, {6'h3F, 26'h0});
    put('h28, i_op(8, 0, 6, 1));
    put('h2C, r_op(0, 6, 5, 'h22));
    put('h30, i_op(8, 0, 7, 'hFFFF));
    put('h34, r_op(7, 6, 8, 'h2A));
    put('h38, r_op(1, 1, 9, 'h3F));
    put('h3C, r_op(1, 1, 0, 'h20));
    put('h40, r_op(0, 0, 9, 'h20));
    put('h44, r_op(5, 1, 10, 'h24));
    put('h48, r_op(1, 6, 11, 'h25));
    rst = 1'b0;
    step(0, "addi_b", c);
    step(0, "j", c);
    check("j_pc", 64'(pc), 64'('h10));
    step(0, "beq_taken", c);
    check("beq_taken_pc", 64'(pc), 64'('h1C));
    step(0, "beq_not_taken", c);
    check("beq_not_taken_pc", 64'(pc), 64'('h20));
    step(0, "jal", c);
    check("jal_pc",  64'(pc),     64'('h100));
    check("jal_r31", 64'(result), 64'('h24));
    step(0, "jr", c);
    check("jr_pc", 64'(pc), 64'('h24));
    step(0, "illegal_op", c);
    check("illegal_op_pulse", 64'(illegal), 64'(1));
    check("illegal_op_result", 64'(result), 64'('h24));
    @(negedge CLK);
    check("illegal_one_cycle", 64'(illegal), 64'(0));
    // realign with the retire-cycle protocol: DUT now one cycle into FETCH
    // of the next instruction, so the following step counts one fewer edge
    model_step(0);
    wait_retire(c);
    check("addi_r6_latency", 64'(c + 1), 64'(exp_cyc));
    check("addi_r6_result", 64'(result), 64'(exp_res));
    step(0, "sub_wrap", c);
    check("sub_wrap32", 64'(result),  64'(32'hFFFF_FFFF));
    check("sub_wrap64", result64,     64'hFFFF_FFFF_FFFF_FFFF);
    step(0, "addi_m1", c);
    step(0, "slt_neg", c);
    check("slt32", 64'(result), 64'(1));
    check("slt64", result64,    64'(1));
    step(0, "illegal_funct", c);
    step(0, "add_to_r0", c);
    step(0, "read_r0", c);
    check("r0_reads_zero", 64'(result), 64'(0));
    step(0, "and", c);
    step(0, "or", c);
    check64 = 1'b0;

    // Program C: reset while a fetch is waiting on memory
    apply_reset();
    clear_mem();
    put('h00, i_op(8, 0, 1, 9));
    put('h04, i_op(8, 1, 2, 1));
    rst = 1'b0;
    step(0, "pre_abort", c);
    cur_wait = 3;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_waiting_req",  64'(mem_req),  64'(1));
    check("abort_waiting_addr", 64'(mem_addr), 64'(4));
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_mem_req", 64'(mem_req), 64'(0));
    check("abort_pc",      64'(pc),      64'(0));
    check("abort_result",  64'(result),  64'(0));
    model_reset();
    rst = 1'b0;
    step(0, "rerun_addi1", c);
    step(0, "rerun_addi2", c);
    check("rerun_value", 64'(result), 64'(10));

    // Program D: random instruction mix with random memory waits
    apply_reset();
    clear_mem();
    for (int i = 0; i < 256; i++) put(4 * i, rand_instr());
    for (int i = 0; i < 64; i++) put('h800 + 4 * i, $urandom());
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step($urandom_range(0, 2), "rand", c);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

  // Absolute time limit; reports and still prints the summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
